// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//
// Sequences a 5-stage pipeline around data hazards and data-memory wait
// states. It sits beside the ID-stage control unit and keeps a shadow copy of
// the destination tags of the instructions in EX and MEM.
//
// Outputs:
//   - ID-stage forwarding selects.
//   - Load-use stall: hold PC and IF/ID, and insert a bubble into EX.
//   - Whole-pipeline freeze while the data memory is busy.
//   - Sticky memory-timeout flag.
//   - Saturating count of stall and freeze cycles.
//
// Ports:
//   clock, reset               rising-edge clock; synchronous active-high reset
//   idRs, idRt                 source register numbers of the ID instruction
//   idUsesRs, idUsesRt         ID instruction really reads rs / rt
//   idWritesRegister           ID instruction writes a register
//   idDestination              resolved destination register of ID instruction
//   idIsLoad                   ID instruction is a load
//   idIsMemoryAccess           ID instruction is a load or a store
//   memoryReady                data memory completes the MEM access this cycle
//   shouldStall                load-use stall
//   shouldFreeze               hold every pipeline register
//   forwardRs, forwardRt       select codes:
//                                0 = regfile
//                                1 = EX ALU result
//                                2 = MEM ALU result
//                                3 = MEM load data
//   memoryTimeout              sticky: freeze lasted MEMORY_TIMEOUT cycles
//   stallCycles                saturating count of stall or freeze cycles
module pipeline_hazard_controller #(
    parameter int MEMORY_TIMEOUT      = 15,
    parameter int STALL_COUNTER_WIDTH = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [4:0]                     idRs,
    input  logic [4:0]                     idRt,
    input  logic                           idUsesRs,
    input  logic                           idUsesRt,
    input  logic                           idWritesRegister,
    input  logic [4:0]                     idDestination,
    input  logic                           idIsLoad,
    input  logic                           idIsMemoryAccess,
    input  logic                           memoryReady,
    output logic                           shouldStall,
    output logic                           shouldFreeze,
    output logic [1:0]                     forwardRs,
    output logic [1:0]                     forwardRt,
    output logic                           memoryTimeout,
    output logic [STALL_COUNTER_WIDTH-1:0] stallCycles
);

    typedef struct packed {
        logic       valid;
        logic       writes;
        logic [4:0] dest;
        logic       is_load;
        logic       is_mem;
    } shadow_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEMORY_TIMEOUT);

    // Only EX and MEM are tracked. A WB entry would feed nothing, because
    // the register file writes before it is read and WB is never forwarded.
    shadow_t                        ex_q, mem_q;
    shadow_t                        id_entry;
    logic [7:0]                     freeze_cnt;
    logic                           timeout_q;
    logic [STALL_COUNTER_WIDTH-1:0] stall_cnt;
    logic                           freeze, load_use, stall;

    // EX takes priority over MEM. A load in EX has no data yet, so it never
    // forwards; the load-use stall covers that case instead. Register 0 is
    // hard-wired zero and always comes from the register file.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input shadow_t ex,
                                           input shadow_t mem);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (ex.valid && ex.writes && !ex.is_load && ex.dest == src)
                sel = 2'd1;
            else if (mem.valid && mem.writes && mem.dest == src)
                sel = mem.is_load ? 2'd3 : 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        id_entry         = '0;
        id_entry.valid   = idWritesRegister || idIsMemoryAccess;
        id_entry.writes  = idWritesRegister;
        id_entry.dest    = idDestination;
        id_entry.is_load = idIsLoad;
        id_entry.is_mem  = idIsMemoryAccess;

        freeze = mem_q.valid && mem_q.is_mem && !memoryReady;

        // A nonzero ex_q.dest also keeps register-0 sources from stalling.
        load_use = ex_q.valid && ex_q.is_load && (ex_q.dest != 5'd0)
                   && ((idUsesRs && idRs == ex_q.dest)
                       || (idUsesRt && idRt == ex_q.dest));

        stall = load_use && !freeze;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q       <= '0;
            mem_q      <= '0;
            freeze_cnt <= '0;
            timeout_q  <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            // A freeze holds the shadow state. A stall drains it and puts a
            // bubble into EX.
            if (!freeze) begin
                mem_q <= ex_q;
                ex_q  <= stall ? '0 : id_entry;
            end

            // Run length of the current freeze. It saturates at the
            // threshold so it cannot wrap; the timeout flag is sticky anyway.
            if (freeze) begin
                if (freeze_cnt != TIMEOUT_CNT)
                    freeze_cnt <= freeze_cnt + 8'd1;
                if (freeze_cnt == TIMEOUT_CNT - 8'd1)
                    timeout_q <= 1'b1;
            end else begin
                freeze_cnt <= '0;
            end

            if ((stall || freeze) && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_COUNTER_WIDTH'(1);
        end
    end

    assign shouldFreeze  = freeze;
    assign shouldStall   = stall;
    assign forwardRs     = fwd_sel(idRs, ex_q, mem_q);
    assign forwardRt     = fwd_sel(idRt, ex_q, mem_q);
    assign memoryTimeout = timeout_q;
    assign stallCycles   = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller. It runs directed
// hazard scenarios, then randomized instruction streams. Both are checked
// against a reference model of the in-flight instructions.
module tb_pipeline_hazard_controller;

    localparam int MT  = 4;
    localparam int SCW = 6;
    localparam int SAT = (1 << SCW) - 1;

    logic           clock = 1'b0;
    logic           reset;
    logic [4:0]     idRs, idRt, idDestination;
    logic           idUsesRs, idUsesRt, idWritesRegister, idIsLoad, idIsMemoryAccess;
    logic           memoryReady;
    logic           shouldStall, shouldFreeze, memoryTimeout;
    logic [1:0]     forwardRs, forwardRt;
    logic [SCW-1:0] stallCycles;

    pipeline_hazard_controller #(.MEMORY_TIMEOUT(MT), .STALL_COUNTER_WIDTH(SCW)) dut (
        .clock(clock), .reset(reset),
        .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
        .idWritesRegister(idWritesRegister), .idDestination(idDestination),
        .idIsLoad(idIsLoad), .idIsMemoryAccess(idIsMemoryAccess),
        .memoryReady(memoryReady),
        .shouldStall(shouldStall), .shouldFreeze(shouldFreeze),
        .forwardRs(forwardRs), .forwardRt(forwardRt),
        .memoryTimeout(memoryTimeout), .stallCycles(stallCycles)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model. flight[0] is the instruction in EX; flight[1] is the
    // instruction in MEM.
    typedef struct {
        bit live;
        bit wr;
        int dst;
        bit ld;
        bit acc;
    } instr_t;

    instr_t flight[2];
    int     freeze_run;
    bit     m_timeout;
    int     m_stalls;

    // Values observed on the DUT during the most recent cycle().
    int     o_stall, o_freeze, o_rs, o_rt, o_to, o_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_fwd(input int src);
        if (src == 0) return 0;
        if (flight[0].live && flight[0].wr && !flight[0].ld && flight[0].dst == src) return 1;
        if (flight[1].live && flight[1].wr && flight[1].dst == src) return flight[1].ld ? 3 : 2;
        return 0;
    endfunction

    function automatic bit m_loaduse();
        return flight[0].live && flight[0].ld && flight[0].dst != 0
               && ((idUsesRs && int'(idRs) == flight[0].dst)
                   || (idUsesRt && int'(idRt) == flight[0].dst));
    endfunction

    // One clock cycle:
    //   1. Check the outputs on the falling edge.
    //   2. Advance the model on the rising edge.
    task automatic cycle();
        bit f, s;
        @(negedge clock);
        f = flight[1].live && flight[1].acc && !memoryReady;
        s = m_loaduse() && !f;
        o_stall  = int'(shouldStall);
        o_freeze = int'(shouldFreeze);
        o_rs     = int'(forwardRs);
        o_rt     = int'(forwardRt);
        o_to     = int'(memoryTimeout);
        o_cnt    = int'(stallCycles);
        check("stall",   32'(o_stall),  32'(s));
        check("freeze",  32'(o_freeze), 32'(f));
        check("fwd_rs",  32'(o_rs),     32'(m_fwd(int'(idRs))));
        check("fwd_rt",  32'(o_rt),     32'(m_fwd(int'(idRt))));
        check("timeout", 32'(o_to),     32'(m_timeout));
        check("stalls",  32'(o_cnt),    32'(m_stalls));
        @(posedge clock);
        if (reset) begin
            flight[0].live = 0;
            flight[1].live = 0;
            freeze_run     = 0;
            m_timeout      = 0;
            m_stalls       = 0;
        end else begin
            if ((f || s) && m_stalls < SAT) m_stalls++;
            if (f) begin
                freeze_run++;
                if (freeze_run >= MT) m_timeout = 1;
            end else begin
                freeze_run = 0;
            end
            if (!f) begin
                flight[1] = flight[0];
                flight[0].live = s ? 1'b0 : (idWritesRegister || idIsMemoryAccess);
                flight[0].wr   = idWritesRegister;
                flight[0].dst  = int'(idDestination);
                flight[0].ld   = idIsLoad;
                flight[0].acc  = idIsMemoryAccess;
            end
        end
        #1;
    endtask

    task automatic set_id(input int rs, input int rt, input bit urs, input bit urt,
                          input bit wr, input int dst, input bit ld, input bit acc);
        idRs             = 5'(rs);
        idRt             = 5'(rt);
        idUsesRs         = urs;
        idUsesRt         = urt;
        idWritesRegister = wr;
        idDestination    = 5'(dst);
        idIsLoad         = ld;
        idIsMemoryAccess = acc;
    endtask

    task automatic alu(input int dst, input int rs, input int rt);
        set_id(rs, rt, 1, 1, 1, dst, 0, 0);
    endtask

    task automatic lw(input int dst, input int base);
        set_id(base, 0, 1, 0, 1, dst, 1, 1);
    endtask

    task automatic sw(input int src, input int base);
        set_id(base, src, 1, 1, 0, 0, 0, 1);
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        memoryReady = 1'b1;
        nop();
        cycle();
        reset = 1'b0;
    endtask

    bit held;

    initial begin
        flight[0]   = '{default: 0};
        flight[1]   = '{default: 0};
        freeze_run  = 0;
        m_timeout   = 0;
        m_stalls    = 0;
        reset       = 1'b1;
        memoryReady = 1'b1;
        nop();

        // Reset state: the shadow is empty, so even a dependent-looking
        // instruction sees no hazard.
        do_reset();
        alu(5, 3, 3);
        cycle();
        check("reset_fwd",   32'(o_rs),     32'd0);
        check("reset_stall", 32'(o_stall),  32'd0);
        check("reset_cnt",   32'(o_cnt),    32'd0);

        // EX forward, then MEM forward.
        do_reset();
        alu(3, 1, 2); cycle();
        alu(5, 3, 1); cycle();
        check("ex_fwd_rs",  32'(o_rs), 32'd1);
        alu(6, 0, 3); cycle();
        check("mem_fwd_rt", 32'(o_rt), 32'd2);
        check("zero_rs",    32'(o_rs), 32'd0);

        // Load-use: one stall, then forward from load data.
        do_reset();
        lw(4, 1);     cycle();
        alu(5, 4, 4); cycle();
        check("lu_stall",  32'(o_stall), 32'd1);
        cycle();
        check("lu_stall2", 32'(o_stall), 32'd0);
        check("lu_rs3",    32'(o_rs),    32'd3);
        check("lu_rt3",    32'(o_rt),    32'd3);
        check("lu_cnt",    32'(o_cnt),   32'd1);

        // Register 0: never forwarded, never stalls.
        do_reset();
        alu(0, 1, 2); cycle();
        alu(5, 0, 0); cycle();
        check("r0_rs", 32'(o_rs), 32'd0);
        check("r0_rt", 32'(o_rt), 32'd0);
        lw(0, 1);     cycle();
        alu(6, 0, 0); cycle();
        check("r0_nostall", 32'(o_stall), 32'd0);

        // EX wins over MEM when both write the register.
        alu(7, 1, 2); cycle();
        alu(7, 2, 3); cycle();
        alu(8, 7, 7); cycle();
        check("prio_rs", 32'(o_rs), 32'd1);
        check("prio_rt", 32'(o_rt), 32'd1);

        // Freeze dominates a pending load-use; the stall appears once the
        // memory is ready.
        do_reset();
        lw(4, 1); cycle();
        lw(6, 1); cycle();
        memoryReady = 1'b0;
        alu(7, 6, 6);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("frz_on",  32'(o_freeze), 32'd1);
            check("frz_nos", 32'(o_stall),  32'd0);
        end
        memoryReady = 1'b1;
        cycle();
        check("frz_done",  32'(o_freeze), 32'd0);
        check("frz_stall", 32'(o_stall),  32'd1);
        check("frz_cnt",   32'(o_cnt),    32'd3);

        // Timeout: the flag rises on the 4th freeze edge and stays high.
        do_reset();
        lw(4, 1); cycle();
        nop();    cycle();
        memoryReady = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            check("to_seq", 32'(o_to), (k >= 5) ? 32'd1 : 32'd0);
        end

        // Reset in the middle of a freeze clears everything.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        alu(5, 4, 4);
        cycle();
        check("rst_frz", 32'(o_freeze), 32'd0);
        check("rst_to",  32'(o_to),     32'd0);
        check("rst_cnt", 32'(o_cnt),    32'd0);

        // The stall counter saturates at all-ones.
        do_reset();
        lw(4, 1); cycle();
        nop();    cycle();
        memoryReady = 1'b0;
        repeat (SAT + 6) cycle();
        check("sat_cnt", 32'(o_cnt), 32'(SAT));
        check("sat_to",  32'(o_to),  32'd1);

        // Randomized instruction stream. The instruction in ID is held while
        // the pipeline is stalled or frozen.
        do_reset();
        held = 0;
        for (int n = 0; n < 600; n++) begin
            if (!held) begin
                case ($urandom_range(0, 3))
                    0: alu($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                    1: lw($urandom_range(0, 7), $urandom_range(0, 7));
                    2: sw($urandom_range(0, 7), $urandom_range(0, 7));
                    default: set_id($urandom_range(0, 7), $urandom_range(0, 7),
                                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                    0, 0, 0, 0);
                endcase
            end
            memoryReady = ($urandom_range(0, 9) < 8);
            reset       = ($urandom_range(0, 99) == 0);
            cycle();
            held = (o_stall != 0 || o_freeze != 0) && !reset;
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
